// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : mem_requester
// Brief    : Bus initiator; one load/store at a time, with alignment, target
//            error and timeout detection, and sign/zero extension of loads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_requester #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int MEM_COUNT_W = 2,
    localparam int MEM_CODE_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [ADDR_W-1:0]      i_cmd_addr,
    input  logic [WORD_W-1:0]      i_cmd_wr_data,
    input  logic                   i_cmd_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_cmd_count,
    input  logic                   i_cmd_signed,
    output logic [ADDR_W-1:0]      o_req_addr,
    output logic [WORD_W-1:0]      o_req_wr_data,
    output logic                   o_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_req_count,
    input  logic [WORD_W-1:0]      i_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_res_code,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [WORD_W-1:0]      o_rsp_data,
    output logic [1:0]             o_rsp_err
);

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    // Code 3 is "busy": the target has not finished yet.
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ    = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE   = 2'd2;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TARGET   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]             r_state, w_state_nxt;
    logic [7:0]             r_wait_cnt, w_wait_cnt_nxt;
    logic                   r_signed, w_signed_nxt;
    logic [ADDR_W-1:0]      r_req_addr, w_req_addr_nxt;
    logic [WORD_W-1:0]      r_req_wr_data, w_req_wr_data_nxt;
    logic                   r_req_wr_en, w_req_wr_en_nxt;
    logic [MEM_COUNT_W-1:0] r_req_count, w_req_count_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [WORD_W-1:0]      r_rsp_data, w_rsp_data_nxt;
    logic [1:0]             r_rsp_err, w_rsp_err_nxt;

    logic                   w_misalign;
    logic [WORD_W-1:0]      w_store_data;
    logic [WORD_W-1:0]      w_load_data;

    assign o_cmd_ready   = (r_state == S_IDLE) && !rst;
    assign o_req_addr    = r_req_addr;
    assign o_req_wr_data = r_req_wr_data;
    assign o_req_wr_en   = r_req_wr_en;
    assign o_req_count   = r_req_count;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_err     = r_rsp_err;

    assign w_misalign = ((i_cmd_count == MEM_COUNT_HALF) && i_cmd_addr[0]) ||
                        ((i_cmd_count == MEM_COUNT_WORD) && (i_cmd_addr[1:0] != 2'b00));

    always_comb begin
        w_store_data = i_cmd_wr_data;
        case (i_cmd_count)
            MEM_COUNT_BYTE: w_store_data = {{(WORD_W-8){1'b0}}, i_cmd_wr_data[7:0]};
            MEM_COUNT_HALF: w_store_data = {{(WORD_W-16){1'b0}}, i_cmd_wr_data[15:0]};
            default:        w_store_data = i_cmd_wr_data;
        endcase
    end

    always_comb begin
        w_load_data = i_res_rd_data;
        case (r_req_count)
            MEM_COUNT_BYTE: w_load_data = {{(WORD_W-8){r_signed & i_res_rd_data[7]}},
                                           i_res_rd_data[7:0]};
            MEM_COUNT_HALF: w_load_data = {{(WORD_W-16){r_signed & i_res_rd_data[15]}},
                                           i_res_rd_data[15:0]};
            default:        w_load_data = i_res_rd_data;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_signed_nxt      = r_signed;
        w_req_addr_nxt    = r_req_addr;
        w_req_wr_data_nxt = r_req_wr_data;
        w_req_wr_en_nxt   = r_req_wr_en;
        w_req_count_nxt   = r_req_count;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_err_nxt     = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (w_misalign || (i_cmd_count == MEM_COUNT_NONE)) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = '0;
                        w_rsp_err_nxt   = w_misalign ? ERR_MISALIGN : ERR_OK;
                    end else begin
                        w_state_nxt       = S_ISSUE;
                        w_wait_cnt_nxt    = 8'd0;
                        w_signed_nxt      = i_cmd_signed;
                        w_req_addr_nxt    = i_cmd_addr;
                        w_req_wr_data_nxt = w_store_data;
                        w_req_wr_en_nxt   = i_cmd_wr_en;
                        w_req_count_nxt   = i_cmd_count;
                    end
                end
            end

            S_ISSUE: begin
                // Completion wins over timeout when both land on the same edge.
                if ((r_req_wr_en && (i_res_code == MEM_CODE_WRITE)) ||
                    (!r_req_wr_en && (i_res_code == MEM_CODE_READ))) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = r_req_wr_en ? '0 : w_load_data;
                    w_rsp_err_nxt   = ERR_OK;
                end else if ((i_res_code == MEM_CODE_INVALID) ||
                             (i_res_code == MEM_CODE_READ) ||
                             (i_res_code == MEM_CODE_WRITE)) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = ERR_TARGET;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = ERR_TIMEOUT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end

                if (w_state_nxt == S_RESP) begin
                    w_req_addr_nxt    = '0;
                    w_req_wr_data_nxt = '0;
                    w_req_wr_en_nxt   = 1'b0;
                    w_req_count_nxt   = MEM_COUNT_NONE;
                end
            end

            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = ERR_OK;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_signed      <= 1'b0;
            r_req_addr    <= '0;
            r_req_wr_data <= '0;
            r_req_wr_en   <= 1'b0;
            r_req_count   <= MEM_COUNT_NONE;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= ERR_OK;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_signed      <= w_signed_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_req_wr_data <= w_req_wr_data_nxt;
            r_req_wr_en   <= w_req_wr_en_nxt;
            r_req_count   <= w_req_count_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_requester
// Brief    : Table-driven bench for mem_requester (TIMEOUT = 4) plus a
//            hand-written reset-during-access sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_requester;

    localparam logic [1:0] CNT_NONE = 2'd0;
    localparam logic [1:0] CNT_BYTE = 2'd1;
    localparam logic [1:0] CNT_HALF = 2'd2;
    localparam logic [1:0] CNT_WORD = 2'd3;
    localparam logic [1:0] CODE_INVALID = 2'd0;
    localparam logic [1:0] CODE_READ    = 2'd1;
    localparam logic [1:0] CODE_WRITE   = 2'd2;
    localparam logic [1:0] CODE_BUSY    = 2'd3;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wr_data;
    logic        i_cmd_wr_en;
    logic [1:0]  i_cmd_count;
    logic        i_cmd_signed;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wr_data;
    logic        o_req_wr_en;
    logic [1:0]  o_req_count;
    logic [31:0] i_res_rd_data;
    logic [1:0]  i_res_code;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_requester #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_wr_data (i_cmd_wr_data),
        .i_cmd_wr_en   (i_cmd_wr_en),
        .i_cmd_count   (i_cmd_count),
        .i_cmd_signed  (i_cmd_signed),
        .o_req_addr    (o_req_addr),
        .o_req_wr_data (o_req_wr_data),
        .o_req_wr_en   (o_req_wr_en),
        .o_req_count   (o_req_count),
        .i_res_rd_data (i_res_rd_data),
        .i_res_code    (i_res_code),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  cnt;
        logic        sgn;
        logic [1:0]  code;      // completion code the target returns
        logic [31:0] rdata;
        int          delay;     // ISSUE cycles of BUSY before the code
        int          hold;      // cycles i_rsp_ready is held low
        logic        bus;       // a bus request is expected
        logic [31:0] req_data;  // expected masked store data on the bus
        int          lat;       // cycles from request (or accept) to rsp_valid
        logic [1:0]  err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic wr,
                                logic [1:0] cnt, logic sgn, logic [1:0] code,
                                logic [31:0] rdata, int delay, int hold, logic bus,
                                logic [31:0] req_data, int lat, logic [1:0] err,
                                logic [31:0] data);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.wr = wr; v.cnt = cnt; v.sgn = sgn;
        v.code = code; v.rdata = rdata; v.delay = delay; v.hold = hold;
        v.bus = bus; v.req_data = req_data; v.lat = lat; v.err = err; v.data = data;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (vec %0d): got %h, required %h", name, idx, got, exp);
        end
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_txn(input int idx, input vec_t v);
        logic bus_seen;
        logic stable;
        int   lat;
        bus_seen = 1'b0;
        stable   = 1'b1;
        lat      = -1;
        check("cmd_ready_idle", idx, {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid   = 1'b1;
        i_cmd_addr    = v.addr;
        i_cmd_wr_data = v.wdata;
        i_cmd_wr_en   = v.wr;
        i_cmd_count   = v.cnt;
        i_cmd_signed  = v.sgn;
        i_res_code    = CODE_BUSY;
        i_rsp_ready   = 1'b1;   // high while rsp_valid is low must be ignored
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        if (v.bus) begin
            check("req_count", idx, {30'd0, o_req_count}, {30'd0, v.cnt});
            check("req_wr_en", idx, {31'd0, o_req_wr_en}, {31'd0, v.wr});
            check("req_addr", idx, o_req_addr, v.addr);
            check("req_wr_data", idx, o_req_wr_data, v.req_data);
        end
        for (int j = 0; j < 40; j++) begin
            if (o_req_count != CNT_NONE) bus_seen = 1'b1;
            if (o_rsp_valid) begin
                lat = j;
                break;
            end
            i_res_code    = (j == v.delay) ? v.code : CODE_BUSY;
            i_res_rd_data = v.rdata;
            @(negedge clk);
        end
        i_res_code = CODE_BUSY;
        check("latency", idx, 32'(lat), 32'(v.lat));
        check("bus_seen", idx, {31'd0, bus_seen}, {31'd0, v.bus});
        check("rsp_data", idx, o_rsp_data, v.data);
        check("rsp_err", idx, {30'd0, o_rsp_err}, {30'd0, v.err});
        check("bus_idle_at_rsp", idx, {30'd0, o_req_count}, {30'd0, CNT_NONE});
        if (v.hold > 0) begin
            i_rsp_ready   = 1'b0;
            // A pending command during RESP must not be taken.
            i_cmd_valid   = 1'b1;
            i_cmd_addr    = 32'h100;
            i_cmd_count   = CNT_WORD;
            i_cmd_wr_en   = 1'b0;
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                if (!o_rsp_valid || o_rsp_data !== v.data || o_rsp_err !== v.err ||
                    o_cmd_ready || o_req_count != CNT_NONE)
                    stable = 1'b0;
            end
            check("rsp_hold_stable", idx, {31'd0, stable}, 32'd1);
            i_rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_valid_after_hs", idx, {31'd0, o_rsp_valid}, 32'd0);
        check("cmd_ready_after_hs", idx, {31'd0, o_cmd_ready}, 32'd1);
        check("bus_idle_after_hs", idx, {30'd0, o_req_count}, {30'd0, CNT_NONE});
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_wr_data = '0; i_cmd_wr_en = 1'b0;
        i_cmd_count = CNT_NONE; i_cmd_signed = 1'b0;
        i_res_rd_data = '0; i_res_code = CODE_BUSY; i_rsp_ready = 1'b0;

        //            addr          wdata         wr    cnt       sgn   code          rdata        dly hold bus   req_data     lat err    data
        tbl[0]  = mk(32'h0,        32'hDEADBEEF, 1'b1, CNT_WORD, 1'b0, CODE_WRITE,   32'h0,        0, 0, 1'b1, 32'hDEADBEEF, 1, 2'd0, 32'h0);
        tbl[1]  = mk(32'h1,        32'h0,        1'b0, CNT_BYTE, 1'b1, CODE_READ,    32'h00000080, 1, 0, 1'b1, 32'h0,        2, 2'd0, 32'hFFFFFF80);
        tbl[2]  = mk(32'h1,        32'h0,        1'b0, CNT_BYTE, 1'b0, CODE_READ,    32'h00000080, 0, 0, 1'b1, 32'h0,        1, 2'd0, 32'h00000080);
        tbl[3]  = mk(32'h2,        32'h0,        1'b0, CNT_HALF, 1'b1, CODE_READ,    32'h00008001, 0, 0, 1'b1, 32'h0,        1, 2'd0, 32'hFFFF8001);
        tbl[4]  = mk(32'h3,        32'h1234,     1'b0, CNT_HALF, 1'b0, CODE_READ,    32'h0,        0, 0, 1'b0, 32'h0,        0, 2'd1, 32'h0);
        tbl[5]  = mk(32'h2,        32'h5678,     1'b1, CNT_WORD, 1'b0, CODE_WRITE,   32'h0,        0, 0, 1'b0, 32'h0,        0, 2'd1, 32'h0);
        tbl[6]  = mk(32'h4,        32'h0,        1'b0, CNT_WORD, 1'b0, CODE_READ,    32'h0,       99, 0, 1'b1, 32'h0,        4, 2'd3, 32'h0);
        tbl[7]  = mk(32'h8,        32'h0,        1'b0, CNT_WORD, 1'b0, CODE_READ,    32'h12345678, 3, 0, 1'b1, 32'h0,        4, 2'd0, 32'h12345678);
        tbl[8]  = mk(32'h2,        32'hAAAA5555, 1'b1, CNT_HALF, 1'b0, CODE_INVALID, 32'h0,        0, 5, 1'b1, 32'h00005555, 1, 2'd2, 32'h0);
        tbl[9]  = mk(32'h7,        32'hDEADBEEF, 1'b1, CNT_BYTE, 1'b0, CODE_READ,    32'h0,        1, 0, 1'b1, 32'h000000EF, 2, 2'd2, 32'h0);
        tbl[10] = mk(32'h10,       32'h0,        1'b0, CNT_NONE, 1'b0, CODE_READ,    32'h0,        0, 0, 1'b0, 32'h0,        0, 2'd0, 32'h0);
        tbl[11] = mk(32'hC,        32'h0,        1'b0, CNT_HALF, 1'b0, CODE_READ,    32'hCAFEF00D, 2, 0, 1'b1, 32'h0,        3, 2'd0, 32'h0000F00D);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", -1, {31'd0, o_cmd_ready}, 32'd0);
        check("reset_rsp_valid", -1, {31'd0, o_rsp_valid}, 32'd0);
        check("reset_rsp_data", -1, o_rsp_data, 32'd0);
        check("reset_rsp_err", -1, {30'd0, o_rsp_err}, 32'd0);
        check("reset_req_count", -1, {30'd0, o_req_count}, {30'd0, CNT_NONE});
        check("reset_req_wr_en", -1, {31'd0, o_req_wr_en}, 32'd0);
        check("reset_req_addr", -1, o_req_addr, 32'd0);
        check("reset_req_wr_data", -1, o_req_wr_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_txn(i, tbl[i]);

        // Reset during ISSUE drops the access without a response.
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h40; i_cmd_wr_en = 1'b0;
        i_cmd_count = CNT_WORD; i_cmd_signed = 1'b0; i_res_code = CODE_BUSY;
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        check("mid_rst_issue", 100, {30'd0, o_req_count}, {30'd0, CNT_WORD});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bus_idle", 100, {30'd0, o_req_count}, {30'd0, CNT_NONE});
        check("mid_rst_addr_idle", 100, o_req_addr, 32'd0);
        check("mid_rst_no_rsp", 100, {31'd0, o_rsp_valid}, 32'd0);
        check("mid_rst_cmd_ready", 100, {31'd0, o_cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 100, {31'd0, o_cmd_ready}, 32'd1);
        check("post_rst_no_rsp", 100, {31'd0, o_rsp_valid}, 32'd0);
        run_txn(101, tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
